decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: instruction decode for a 5-stage RV pipeline.
// Decodes one 32-bit instruction per cycle, reads the register file
// (optionally forwarding the same-cycle write), detects load-use hazards,
// produces a combinational JAL redirect and registers everything into the
// EX pipeline register.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   if_valid/if_pc/if_inst    instruction from IF
//   id_ready                  0 = stall, IF must hold
//   flush                     kill the instruction in decode
//   ex_memread, ex_load_rd    load in EX and its destination register
//                             (hazard input; ex_rd is the EX-register output)
//   wb_we/wb_addr/wb_data     register-file write port
//   jal_redirect/jal_target   JAL redirect to IF
//   ex_*                      registered EX-stage slot
module decode_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  output logic            id_ready,
  input  logic            flush,
  input  logic            ex_memread,
  input  logic [4:0]      ex_load_rd,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            jal_redirect,
  output logic [XLEN-1:0] jal_target,
  output logic            ex_valid,
  output logic            ex_illegal,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rdata1,
  output logic [XLEN-1:0] ex_rdata2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [1:0]      ex_ctrl_wb,
  output logic [1:0]      ex_ctrl_m,
  output logic [3:0]      ex_ctrl_ex
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] r_regs [NREG];

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm;
  logic [1:0]      w_wb, w_m;
  logic [3:0]      w_ex;
  logic            w_legal, w_use1, w_use2, w_userd, w_is_jal;
  logic            w_rs1_inr, w_rs2_inr, w_rd_inr, w_illegal;
  logic            w_hazard, w_stall;
  logic [XLEN-1:0] w_rdata1, w_rdata2;

  assign w_op  = if_inst[6:0];
  assign w_rd  = if_inst[11:7];
  assign w_f3  = if_inst[14:12];
  assign w_rs1 = if_inst[19:15];
  assign w_rs2 = if_inst[24:20];
  assign w_f7  = if_inst[31:25];

  assign w_imm_i = {{(XLEN-12){if_inst[31]}}, if_inst[31:20]};
  assign w_imm_s = {{(XLEN-12){if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
  assign w_imm_b = {{(XLEN-13){if_inst[31]}}, if_inst[31], if_inst[7],
                    if_inst[30:25], if_inst[11:8], 1'b0};
  assign w_imm_j = {{(XLEN-21){if_inst[31]}}, if_inst[31], if_inst[19:12],
                    if_inst[20], if_inst[30:21], 1'b0};

  assign w_rs1_inr = 32'(w_rs1) < NREG;
  assign w_rs2_inr = 32'(w_rs2) < NREG;
  assign w_rd_inr  = 32'(w_rd)  < NREG;

  always_comb begin
    w_legal  = 1'b0;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_userd  = 1'b0;
    w_is_jal = 1'b0;
    w_imm    = '0;
    w_wb     = 2'b00;
    w_m      = 2'b00;
    w_ex     = 4'b0000;
    case (w_op)
      7'b0110011: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_userd = 1'b1;
        w_wb    = 2'b10;
        w_legal = 1'b1;
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_ex = 4'b0000;
            3'b001:  w_ex = 4'b0100;
            3'b010:  w_ex = 4'b0101;
            3'b111:  w_ex = 4'b0010;
            3'b110:  w_ex = 4'b0011;
            default: w_legal = 1'b0;
          endcase
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_ex = 4'b0001;
        end else begin
          w_legal = 1'b0;
        end
      end
      7'b0010011: begin
        w_use1  = 1'b1;
        w_userd = 1'b1;
        w_imm   = w_imm_i;
        w_legal = (w_f3 == 3'b000);
        w_wb    = 2'b10;
        w_ex    = 4'b1000;
      end
      7'b0000011: begin
        w_use1  = 1'b1;
        w_userd = 1'b1;
        w_imm   = w_imm_i;
        w_legal = (w_f3 == 3'b011);
        w_wb    = 2'b11;
        w_m     = 2'b10;
        w_ex    = 4'b1000;
      end
      7'b0100011: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_imm   = w_imm_s;
        w_legal = (w_f3 == 3'b011);
        w_m     = 2'b01;
        w_ex    = 4'b1000;
      end
      7'b1100011: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_imm   = w_imm_b;
        w_legal = 1'b1;
        w_ex    = 4'b0001;
      end
      7'b1100111: begin
        w_use1  = 1'b1;
        w_userd = 1'b1;
        w_imm   = w_imm_i;
        w_legal = 1'b1;
        w_wb    = 2'b10;
        w_ex    = 4'b1000;
      end
      7'b1101111: begin
        w_userd  = 1'b1;
        w_is_jal = 1'b1;
        w_imm    = w_imm_j;
        w_legal  = 1'b1;
        w_wb     = 2'b10;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Only register fields the format actually uses are range-checked; the
  // same bit positions hold immediate bits in other formats.
  assign w_illegal = !(w_legal && (!w_use1 || w_rs1_inr) &&
                       (!w_use2 || w_rs2_inr) && (!w_userd || w_rd_inr));

  assign w_hazard = if_valid && ex_memread && (ex_load_rd != 5'd0) &&
                    ((w_use1 && ex_load_rd == w_rs1) ||
                     (w_use2 && ex_load_rd == w_rs2));
  // flush wins over a load-use stall: the instruction dies anyway
  assign w_stall  = w_hazard && !flush;
  assign id_ready = !w_stall;

  assign jal_redirect = if_valid && w_is_jal && !w_stall && !flush;
  assign jal_target   = if_pc + w_imm_j;

  always_comb begin
    w_rdata1 = '0;
    w_rdata2 = '0;
    if (w_rs1 != 5'd0 && w_rs1_inr)
      w_rdata1 = (BYPASS && wb_we && wb_addr == w_rs1) ? wb_data
                                                       : r_regs[w_rs1[AW-1:0]];
    if (w_rs2 != 5'd0 && w_rs2_inr)
      w_rdata2 = (BYPASS && wb_we && wb_addr == w_rs2) ? wb_data
                                                       : r_regs[w_rs2[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0 && 32'(wb_addr) < NREG) begin
      r_regs[wb_addr[AW-1:0]] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush || w_stall) begin
      if (!reset_n || flush || w_stall) begin
        ex_valid   <= 1'b0;
        ex_illegal <= 1'b0;
        ex_pc      <= '0;
        ex_rdata1  <= '0;
        ex_rdata2  <= '0;
        ex_imm     <= '0;
        ex_rs1     <= '0;
        ex_rs2     <= '0;
        ex_rd      <= '0;
        ex_ctrl_wb <= '0;
        ex_ctrl_m  <= '0;
        ex_ctrl_ex <= '0;
      end
    end else begin
      ex_valid   <= if_valid;
      ex_illegal <= if_valid && w_illegal;
      ex_pc      <= if_pc;
      ex_rdata1  <= w_rdata1;
      ex_rdata2  <= w_rdata2;
      ex_imm     <= w_imm;
      ex_rs1     <= w_rs1;
      ex_rs2     <= w_rs2;
      ex_rd      <= w_rd;
      ex_ctrl_wb <= (if_valid && !w_illegal) ? w_wb : 2'b00;
      ex_ctrl_m  <= (if_valid && !w_illegal) ? w_m  : 2'b00;
      ex_ctrl_ex <= (if_valid && !w_illegal) ? w_ex : 4'b0000;
    end
  end

endmodule
